// File: rtl/demux_pkg.sv
// ============================================================================
// Module  : demux_pkg
// Purpose : Shared mode encodings and width helpers for the 1-to-N demux.
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

package demux_pkg;

   localparam logic MODE_ADDR = 1'b0;
   localparam logic MODE_RR   = 1'b1;

   function automatic int clog2(input int value);
      int r;
      int v;
      r = 0;
      v = value - 1;
      while (v > 0) begin
         r = r + 1;
         v = v >> 1;
      end
      return r;
   endfunction

   // A single channel still needs a one-bit select.
   function automatic int sel_width(input int n);
      return (clog2(n) > 1) ? clog2(n) : 1;
   endfunction

endpackage

`default_nettype wire

// File: rtl/demux_hold_slot.sv
// ============================================================================
// Module  : demux_hold_slot
// Purpose : One-entry valid/data holding register; a load wins over a pop.
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

module demux_hold_slot #(
   parameter int DATA_W = 8
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              i_load,
   input  logic              i_pop,
   input  logic [DATA_W-1:0] i_data,
   output logic              o_valid,
   output logic [DATA_W-1:0] o_data
);

   logic              r_valid;
   logic [DATA_W-1:0] r_data;

   // Load first: a simultaneous pop and reload keeps the slot full, no bubble.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_valid <= 1'b0;
         r_data  <= '0;
      end else if (i_load) begin
         r_valid <= 1'b1;
         r_data  <= i_data;
      end else if (i_pop) begin
         r_valid <= 1'b0;
      end
   end

   assign o_valid = r_valid;
   assign o_data  = r_data;

endmodule

`default_nettype wire

// File: rtl/demux_reg_1ton.sv
// ============================================================================
// Module  : demux_reg_1ton
// Purpose : Registered 1-to-N demux, addressed or round-robin routing.
//           Define DEMUX_REG_ERR_EN to enable the out-of-range err pulse.
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

module demux_reg_1ton
   import demux_pkg::*;
#(
   parameter  int N      = 8,
   parameter  int DATA_W = 8,
   localparam int SEL_W  = sel_width(N)
) (
   input  logic                clk,
   input  logic                rst_n,
   input  logic                mode,
   input  logic                in_valid,
   output logic                in_ready,
   input  logic [SEL_W-1:0]    in_sel,
   input  logic [DATA_W-1:0]   in_data,
   output logic [N-1:0]        out_valid,
   input  logic [N-1:0]        out_ready,
   output logic [N*DATA_W-1:0] out_data,
   output logic                err
);

   logic [SEL_W-1:0] r_rr_ptr;
   logic [SEL_W-1:0] w_tgt;
   logic [N-1:0]     w_hit;
   logic [N-1:0]     w_load;
   logic [N-1:0]     w_pop;
   logic             w_in_range;
   logic             w_xfer;

   assign w_tgt = (mode == MODE_RR) ? r_rr_ptr : in_sel;

   for (genvar k = 0; k < N; k++) begin : g_chan
      assign w_hit[k]  = (w_tgt == SEL_W'(k));
      assign w_load[k] = w_xfer & w_hit[k];
      assign w_pop[k]  = out_valid[k] & out_ready[k];

      demux_hold_slot #(
         .DATA_W (DATA_W)
      ) u_slot (
         .clk     (clk),
         .rst_n   (rst_n),
         .i_load  (w_load[k]),
         .i_pop   (w_pop[k]),
         .i_data  (in_data),
         .o_valid (out_valid[k]),
         .o_data  (out_data[k*DATA_W +: DATA_W])
      );
   end

   // No channel matches an out-of-range target, so such offers are always accepted.
   assign w_in_range = |w_hit;
   assign in_ready   = ~|(w_hit & out_valid & ~out_ready);
   assign w_xfer     = in_valid & in_ready;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_rr_ptr <= '0;
      end else if (w_xfer && w_in_range && (mode == MODE_RR)) begin
         r_rr_ptr <= (r_rr_ptr == SEL_W'(N - 1)) ? '0 : r_rr_ptr + SEL_W'(1);
      end
   end

`ifdef DEMUX_REG_ERR_EN
   logic r_err;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_err <= 1'b0;
      end else begin
         r_err <= w_xfer & ~w_in_range;
      end
   end

   assign err = r_err;
`else
   assign err = 1'b0;
`endif

endmodule

`default_nettype wire

// File: tb/tb_demux_reg_1ton.sv
// ============================================================================
// Module  : tb_demux_reg_1ton
// Purpose : Directed table-driven bench for demux_reg_1ton (N=8 and N=6).
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_demux_reg_1ton;

`ifdef DEMUX_REG_ERR_EN
   localparam logic EXP_ERR = 1'b1;
`else
   localparam logic EXP_ERR = 1'b0;
`endif

   logic        clk;
   logic        rst_n;

   logic        mode8, in_valid8, in_ready8, err8;
   logic [2:0]  in_sel8;
   logic [7:0]  in_data8, out_valid8, out_ready8;
   logic [63:0] out_data8;

   logic        mode6, in_valid6, in_ready6, err6;
   logic [2:0]  in_sel6;
   logic [7:0]  in_data6;
   logic [5:0]  out_valid6, out_ready6;
   logic [47:0] out_data6;

   int n_checks = 0;
   int n_errors = 0;

   demux_reg_1ton #(.N(8), .DATA_W(8)) dut8 (
      .clk(clk), .rst_n(rst_n), .mode(mode8), .in_valid(in_valid8),
      .in_ready(in_ready8), .in_sel(in_sel8), .in_data(in_data8),
      .out_valid(out_valid8), .out_ready(out_ready8), .out_data(out_data8),
      .err(err8)
   );

   demux_reg_1ton #(.N(6), .DATA_W(8)) dut6 (
      .clk(clk), .rst_n(rst_n), .mode(mode6), .in_valid(in_valid6),
      .in_ready(in_ready6), .in_sel(in_sel6), .in_data(in_data6),
      .out_valid(out_valid6), .out_ready(out_ready6), .out_data(out_data6),
      .err(err6)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   typedef struct {
      logic       mode;
      logic       valid;
      logic [2:0] sel;
      logic [7:0] data;
      logic [7:0] ordy;
      logic       exp_ir;
      logic [7:0] exp_ov;
      int         ch;
      logic [7:0] exp_ch;
   } vec_t;

   vec_t vecs[27];

   function automatic vec_t mk(input logic m, input logic v, input logic [2:0] s,
                               input logic [7:0] d, input logic [7:0] r, input logic ir,
                               input logic [7:0] ov, input int ch, input logic [7:0] cd);
      vec_t t;
      t.mode = m; t.valid = v; t.sel = s; t.data = d; t.ordy = r;
      t.exp_ir = ir; t.exp_ov = ov; t.ch = ch; t.exp_ch = cd;
      return t;
   endfunction

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_errors++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   task automatic run_vec(input int i);
      mode8      = vecs[i].mode;
      in_valid8  = vecs[i].valid;
      in_sel8    = vecs[i].sel;
      in_data8   = vecs[i].data;
      out_ready8 = vecs[i].ordy;
      @(negedge clk);
      check($sformatf("vec%0d in_ready", i), 64'(in_ready8), 64'(vecs[i].exp_ir));
      check($sformatf("vec%0d out_valid", i), 64'(out_valid8), 64'(vecs[i].exp_ov));
      check($sformatf("vec%0d ch%0d data", i, vecs[i].ch),
            64'(out_data8[vecs[i].ch*8 +: 8]), 64'(vecs[i].exp_ch));
      @(posedge clk);
      #1;
   endtask

   initial begin
      // Addressed load/hold, backpressure, pass-through, drain.
      vecs[0]  = mk(0, 1, 3, 8'hA5, 8'h00, 1, 8'h00, 3, 8'h00);
      vecs[1]  = mk(0, 0, 3, 8'h00, 8'h00, 0, 8'h08, 3, 8'hA5);
      vecs[2]  = mk(0, 0, 3, 8'h00, 8'h00, 0, 8'h08, 3, 8'hA5);
      vecs[3]  = mk(0, 1, 3, 8'h5A, 8'h00, 0, 8'h08, 3, 8'hA5);
      vecs[4]  = mk(0, 1, 3, 8'h5A, 8'h08, 1, 8'h08, 3, 8'hA5);
      vecs[5]  = mk(0, 0, 3, 8'h00, 8'h00, 0, 8'h08, 3, 8'h5A);
      vecs[6]  = mk(0, 0, 3, 8'h00, 8'hFF, 1, 8'h08, 3, 8'h5A);
      vecs[7]  = mk(0, 0, 3, 8'h00, 8'hFF, 1, 8'h00, 3, 8'h5A);
      // Round-robin, 10 back-to-back transfers with wrap.
      vecs[8]  = mk(1, 1, 0, 8'h00, 8'hFF, 1, 8'h00, 0, 8'h00);
      vecs[9]  = mk(1, 1, 0, 8'h01, 8'hFF, 1, 8'h01, 0, 8'h00);
      vecs[10] = mk(1, 1, 0, 8'h02, 8'hFF, 1, 8'h02, 1, 8'h01);
      vecs[11] = mk(1, 1, 0, 8'h03, 8'hFF, 1, 8'h04, 2, 8'h02);
      vecs[12] = mk(1, 1, 0, 8'h04, 8'hFF, 1, 8'h08, 3, 8'h03);
      vecs[13] = mk(1, 1, 0, 8'h05, 8'hFF, 1, 8'h10, 4, 8'h04);
      vecs[14] = mk(1, 1, 0, 8'h06, 8'hFF, 1, 8'h20, 5, 8'h05);
      vecs[15] = mk(1, 1, 0, 8'h07, 8'hFF, 1, 8'h40, 6, 8'h06);
      vecs[16] = mk(1, 1, 0, 8'h08, 8'hFF, 1, 8'h80, 7, 8'h07);
      vecs[17] = mk(1, 1, 0, 8'h09, 8'hFF, 1, 8'h01, 0, 8'h08);
      vecs[18] = mk(1, 0, 0, 8'h00, 8'h00, 1, 8'h02, 1, 8'h09);
      vecs[19] = mk(1, 1, 0, 8'h0A, 8'h00, 1, 8'h02, 1, 8'h09);
      vecs[20] = mk(0, 0, 0, 8'h00, 8'h00, 1, 8'h06, 2, 8'h0A);
      // After reset: three RR, one addressed, RR resumes at ch3.
      vecs[21] = mk(1, 1, 0, 8'h11, 8'h00, 1, 8'h00, 0, 8'h00);
      vecs[22] = mk(1, 1, 0, 8'h22, 8'h00, 1, 8'h01, 0, 8'h11);
      vecs[23] = mk(1, 1, 0, 8'h33, 8'h00, 1, 8'h03, 1, 8'h22);
      vecs[24] = mk(0, 1, 6, 8'h66, 8'h00, 1, 8'h07, 2, 8'h33);
      vecs[25] = mk(1, 1, 0, 8'h44, 8'h00, 1, 8'h47, 6, 8'h66);
      vecs[26] = mk(1, 0, 0, 8'h00, 8'h00, 1, 8'h4F, 3, 8'h44);

      rst_n = 1'b0;
      mode8 = 0; in_valid8 = 0; in_sel8 = 0; in_data8 = 0; out_ready8 = 0;
      mode6 = 0; in_valid6 = 0; in_sel6 = 0; in_data6 = 0; out_ready6 = 0;
      repeat (3) @(posedge clk);
      @(negedge clk);
      check("reset out_valid", 64'(out_valid8), 64'h0);
      check("reset out_data", out_data8, 64'h0);
      check("reset err", 64'(err8), 64'h0);
      rst_n = 1'b1;
      @(posedge clk);
      #1;

      for (int i = 0; i <= 20; i++) run_vec(i);

      // Fill ch5 while ch1 drains, leaving ch2 and ch5 valid.
      mode8 = 0; in_valid8 = 1; in_sel8 = 5; in_data8 = 8'h55; out_ready8 = 8'h02;
      @(negedge clk);
      check("fill ch5 in_ready", 64'(in_ready8), 64'h1);
      @(posedge clk);
      #1;
      in_valid8 = 0; out_ready8 = 8'h00;
      @(negedge clk);
      check("pre-reset out_valid", 64'(out_valid8), 64'h24);
      #2;
      rst_n = 1'b0;
      #1;
      check("async reset out_valid", 64'(out_valid8), 64'h0);
      check("async reset out_data", out_data8, 64'h0);
      mode8 = 1; in_valid8 = 1; in_data8 = 8'h77;
      @(posedge clk);
      #1;
      check("no xfer in reset", 64'(out_valid8), 64'h0);
      in_valid8 = 0;
      @(negedge clk);
      rst_n = 1'b1;
      @(posedge clk);
      #1;

      for (int i = 21; i <= 26; i++) run_vec(i);

      // N=6: in-range load, then out-of-range drops at sel=7 and sel=6.
      mode6 = 0; in_valid6 = 1; in_sel6 = 1; in_data6 = 8'hC3;
      @(negedge clk);
      check("n6 load in_ready", 64'(in_ready6), 64'h1);
      @(posedge clk);
      #1;
      in_sel6 = 7; in_data6 = 8'hEE;
      @(negedge clk);
      check("n6 sel7 in_ready", 64'(in_ready6), 64'h1);
      check("n6 pre-drop out_valid", 64'(out_valid6), 64'h02);
      check("n6 pre-drop err", 64'(err6), 64'h0);
      @(posedge clk);
      #1;
      in_valid6 = 0;
      check("n6 sel7 out_valid", 64'(out_valid6), 64'h02);
      check("n6 sel7 err", 64'(err6), 64'(EXP_ERR));
      check("n6 ch1 data", 64'(out_data6[15:8]), 64'hC3);
      @(posedge clk);
      #1;
      check("n6 err one cycle", 64'(err6), 64'h0);
      in_valid6 = 1; in_sel6 = 6; in_data6 = 8'hDD;
      @(posedge clk);
      #1;
      in_valid6 = 0;
      check("n6 sel6 out_valid", 64'(out_valid6), 64'h02);
      check("n6 sel6 err", 64'(err6), 64'(EXP_ERR));
      in_valid6 = 1; in_sel6 = 5; in_data6 = 8'hB5;
      @(negedge clk);
      check("n6 sel5 in_ready", 64'(in_ready6), 64'h1);
      @(posedge clk);
      #1;
      in_valid6 = 0;
      check("n6 sel5 out_valid", 64'(out_valid6), 64'h22);
      check("n6 sel5 data", 64'(out_data6[47:40]), 64'hB5);
      check("n6 sel5 err", 64'(err6), 64'h0);

      $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
      $finish;
   end

endmodule

`default_nettype wire
